eth_frame_monitor: RTL and testbench

//  Parametrised successor to the ad-hoc frame counter/display latch in the RMII receive top level.

---
 rtl/eth_mon_pkg.sv | 17 +
 rtl/eth_frame_monitor_if.sv | 29 ++
 rtl/mon_ring_buf.sv | 48 ++++
 rtl/eth_frame_monitor.sv | 136 +++++++++++++
 tb/tb_eth_frame_monitor.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/eth_mon_pkg.sv
// Shared types and constants for the Ethernet receive-side frame monitor.
package eth_mon_pkg;

  typedef enum logic [1:0] {
    MODE_LAST    = 2'd0,
    MODE_FRAMES  = 2'd1,
    MODE_GOODBAD = 2'd2,
    MODE_HIST    = 2'd3
  } disp_mode_t;

  // Width of the frame-count field on the status LEDs
  localparam int LED_CNT_W = 14;

  // Half of the display word, used for the packed good/bad and length/frame views
  localparam int DISP_HALF_W = 16;

endpackage : eth_mon_pkg

// File: rtl/eth_frame_monitor_if.sv
// Bus bundle between the receive chain taps and the frame monitor.
interface eth_frame_monitor_if #(
  parameter int DATA_W = 32
);
  import eth_mon_pkg::*;

  // Handshake: every input is a pure observation of the receive chain; agg_v is a
  // one-cycle valid with no ready/back-pressure, so each pulse must be consumed in that cycle.
  logic              eth_v;
  logic              ck_done;
  logic              ck_kill;
  logic              agg_v;
  logic [DATA_W-1:0] agg_d;
  disp_mode_t        mode;
  logic              hist_next;
  logic [DATA_W-1:0] val_out;
  logic [15:0]       led_out;

  modport master (
    output eth_v, ck_done, ck_kill, agg_v, agg_d, mode, hist_next,
    input  val_out, led_out
  );

  modport slave (
    input  eth_v, ck_done, ck_kill, agg_v, agg_d, mode, hist_next,
    output val_out, led_out
  );

endinterface : eth_frame_monitor_if

// File: rtl/mon_ring_buf.sv
// Overwrite-oldest history of aggregate words with reads addressed relative to the newest entry.
module mon_ring_buf #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] newest_data,
  output logic [AW:0]       fill
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     newest_addr;
  logic [AW-1:0]     rd_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + AW'(1);
      if (fill != (AW+1)'(DEPTH)) begin
        fill <= fill + (AW+1)'(1);
      end
    end
  end

  // Storage carries no reset; fill guards every read of stale contents
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointer arithmetic wraps naturally
  assign newest_addr = wr_ptr - AW'(1);
  assign rd_addr     = wr_ptr - AW'(1) - rd_idx;

  assign newest_data = (fill == '0) ? '0 : mem[newest_addr];
  assign rd_data     = (fill == '0) ? '0 : mem[rd_addr];

endmodule : mon_ring_buf

// File: rtl/eth_frame_monitor.sv
// Frame/good/bad counters, aggregate history and display/LED drive for the RMII receive path.
// Optional ETH_MON_BYTELEN_EN adds per-frame byte length to the MODE_FRAMES display.
module eth_frame_monitor
  import eth_mon_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input logic               clk,
  input logic               rst,
  eth_frame_monitor_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              eth_v_q;
  logic              ck_done_q;
  logic [CNT_W-1:0]  frame_cnt;
  logic [CNT_W-1:0]  good_cnt;
  logic [CNT_W-1:0]  bad_cnt;
  logic [AW-1:0]     hist_idx;
  logic [AW:0]       fill;
  logic [DATA_W-1:0] hist_data;
  logic [DATA_W-1:0] newest_data;
  logic [DATA_W-1:0] val_q;
  logic [DATA_W-1:0] val_nxt;
  logic [15:0]       led_q;
  logic [15:0]       led_nxt;

  logic frame_end;
  logic ck_rise;
  logic hist_last;

  assign frame_end = eth_v_q && !bus.eth_v;
  assign ck_rise   = bus.ck_done && !ck_done_q;
  assign hist_last = ({1'b0, hist_idx} >= (fill - (AW+1)'(1)));

  mon_ring_buf #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ring (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (bus.agg_v),
    .wr_data     (bus.agg_d),
    .rd_idx      (hist_idx),
    .rd_data     (hist_data),
    .newest_data (newest_data),
    .fill        (fill)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      eth_v_q   <= 1'b0;
      ck_done_q <= 1'b0;
      frame_cnt <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      hist_idx  <= '0;
      val_q     <= '0;
      led_q     <= '0;
    end else begin
      eth_v_q   <= bus.eth_v;
      ck_done_q <= bus.ck_done;
      if (frame_end && frame_cnt != CNT_MAX) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
      if (ck_rise && bus.ck_kill && bad_cnt != CNT_MAX) begin
        bad_cnt <= bad_cnt + CNT_W'(1);
      end
      if (ck_rise && !bus.ck_kill && good_cnt != CNT_MAX) begin
        good_cnt <= good_cnt + CNT_W'(1);
      end
      // Browsing index wraps against the current fill; it stays at 0 while empty
      if (bus.hist_next) begin
        hist_idx <= (fill == '0 || hist_last) ? '0 : hist_idx + AW'(1);
      end
      val_q <= val_nxt;
      led_q <= led_nxt;
    end
  end

`ifdef ETH_MON_BYTELEN_EN
  logic [15:0] dibit_cnt;
  logic [15:0] last_len;

  // One eth_v cycle is one RMII dibit; four dibits make a byte
  always_ff @(posedge clk) begin
    if (rst) begin
      dibit_cnt <= '0;
      last_len  <= '0;
    end else if (frame_end) begin
      last_len  <= dibit_cnt >> 2;
      dibit_cnt <= '0;
    end else if (bus.eth_v && dibit_cnt != 16'hFFFF) begin
      dibit_cnt <= dibit_cnt + 16'd1;
    end
  end
`endif

  logic [31:0]                  frame_ext;
  logic [31:0]                  good_ext;
  logic [31:0]                  bad_ext;
  logic [DISP_HALF_W-1:0]       good16;
  logic [DISP_HALF_W-1:0]       bad16;
  logic [LED_CNT_W-1:0]         frame_led;

  assign frame_ext = 32'(frame_cnt);
  assign good_ext  = 32'(good_cnt);
  assign bad_ext   = 32'(bad_cnt);
  assign good16    = (good_ext > 32'h0000_FFFF) ? '1 : good_ext[DISP_HALF_W-1:0];
  assign bad16     = (bad_ext  > 32'h0000_FFFF) ? '1 : bad_ext[DISP_HALF_W-1:0];
  assign frame_led = (frame_ext > 32'((1 << LED_CNT_W) - 1)) ? '1 : frame_ext[LED_CNT_W-1:0];

  always_comb begin
    val_nxt = '0;
    led_nxt = {bus.ck_kill, bus.ck_done, frame_led};
    case (bus.mode)
      MODE_LAST:    val_nxt = newest_data;
`ifdef ETH_MON_BYTELEN_EN
      MODE_FRAMES:  val_nxt = DATA_W'({last_len, frame_ext[15:0]});
`else
      MODE_FRAMES:  val_nxt = DATA_W'(frame_ext);
`endif
      MODE_GOODBAD: val_nxt = DATA_W'({good16, bad16});
      MODE_HIST:    val_nxt = hist_data;
      default:      val_nxt = '0;
    endcase
  end

  assign bus.val_out = val_q;
  assign bus.led_out = led_q;

endmodule : eth_frame_monitor

// File: tb/tb_eth_frame_monitor.sv
// Directed bench for eth_frame_monitor: mode table plus history, reset, empty and saturation sequences.
module tb_eth_frame_monitor;
  import eth_mon_pkg::*;

  logic eth_refclk = 1'b0;
  logic rst;

  always #10 eth_refclk = ~eth_refclk;

  eth_frame_monitor_if #(.DATA_W(32)) bus  ();
  eth_frame_monitor_if #(.DATA_W(32)) bus8 ();

  eth_frame_monitor #(.CNT_W(16), .DEPTH(8), .DATA_W(32)) u_dut (
    .clk (eth_refclk),
    .rst (rst),
    .bus (bus.slave)
  );

  eth_frame_monitor #(.CNT_W(8), .DEPTH(8), .DATA_W(32)) u_dut8 (
    .clk (eth_refclk),
    .rst (rst),
    .bus (bus8.slave)
  );

  typedef struct {
    string      name;
    disp_mode_t mode;
    logic [31:0] exp_val;
    logic [15:0] exp_led;
  } vec_t;

  vec_t        vecs[4];
  logic [31:0] exp_q[$];
  int          tests_run    = 0;
  int          tests_failed = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge eth_refclk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.eth_v = 0; bus.ck_done = 0; bus.ck_kill = 0; bus.agg_v = 0;
    bus.agg_d = '0; bus.mode = MODE_LAST; bus.hist_next = 0;
    bus8.eth_v = 0; bus8.ck_done = 0; bus8.ck_kill = 0; bus8.agg_v = 0;
    bus8.agg_d = '0; bus8.mode = MODE_FRAMES; bus8.hist_next = 0;
  endtask

  task automatic frame(input int len);
    bus.eth_v = 1;
    tick(len);
    bus.eth_v = 0;
    tick(1);
  endtask

  task automatic ck_pulse(input logic kill, input logic kill_early);
    if (kill_early) begin
      bus.ck_kill = kill;
      tick(1);
    end
    bus.ck_done = 1;
    bus.ck_kill = kill;
    tick(2);
    bus.ck_done = 0;
    bus.ck_kill = 0;
    tick(2);
  endtask

  task automatic agg_write(input logic [31:0] d);
    bus.agg_v = 1;
    bus.agg_d = d;
    tick(1);
    bus.agg_v = 0;
  endtask

  task automatic hist_pulse();
    bus.hist_next = 1;
    tick(1);
    bus.hist_next = 0;
  endtask

  initial begin
    logic [31:0] exp_frames;
`ifdef ETH_MON_BYTELEN_EN
    exp_frames = {16'd1, 16'd3};
`else
    exp_frames = 32'd3;
`endif
    vecs[0] = '{"mode_last",    MODE_LAST,    32'd10,        16'h0003};
    vecs[1] = '{"mode_frames",  MODE_FRAMES,  exp_frames,    16'h0003};
    vecs[2] = '{"mode_goodbad", MODE_GOODBAD, 32'h0002_0002, 16'h0003};
    vecs[3] = '{"mode_hist",    MODE_HIST,    32'd10,        16'h0003};

    idle_inputs();
    rst = 1;
    tick(3);
    check("reset_val", bus.val_out, 32'd0);
    check("reset_led", {16'd0, bus.led_out}, 32'd0);
    rst = 0;
    tick(1);

    bus.mode = MODE_FRAMES;
    frame(10);
    tick(2);
    frame(20);
    tick(2);
    frame(5);
    tick(1);
    check("frames_latency", bus.val_out, exp_frames);

    ck_pulse(1'b0, 1'b0);
    ck_pulse(1'b1, 1'b1);
    ck_pulse(1'b0, 1'b0);
    ck_pulse(1'b1, 1'b0);

    for (int i = 1; i <= 10; i++) agg_write(32'(i));
    tick(1);

    for (int i = 0; i < 4; i++) begin
      bus.mode = vecs[i].mode;
      tick(2);
      check({vecs[i].name, "_val"}, bus.val_out, vecs[i].exp_val);
      check({vecs[i].name, "_led"}, {16'd0, bus.led_out}, {16'd0, vecs[i].exp_led});
    end

    // Level bits on LEDs, and kill sampled at the done edge counts a bad check
    bus.mode    = MODE_GOODBAD;
    bus.ck_done = 1;
    bus.ck_kill = 1;
    tick(2);
    check("led_ck_bits", {16'd0, bus.led_out}, 32'h0000_C003);
    check("goodbad_after_kill", bus.val_out, 32'h0002_0003);
    bus.ck_done = 0;
    bus.ck_kill = 0;
    tick(2);

    // Browse the full history: newest is 10, oldest retained is 3, then wrap
    bus.mode = MODE_HIST;
    tick(2);
    for (int p = 0; p <= 9; p++) exp_q.push_back(32'(10 - (p % 8)));
    check("hist_step0", bus.val_out, exp_q.pop_front());
    for (int p = 1; p <= 9; p++) begin
      hist_pulse();
      tick(1);
      check($sformatf("hist_step%0d", p), bus.val_out, exp_q.pop_front());
    end

    // Reset mid-frame together with agg_v and hist_next
    bus.mode = MODE_FRAMES;
    bus.eth_v = 1;
    tick(3);
    rst = 1;
    bus.agg_v = 1;
    bus.agg_d = 32'h1234_5678;
    bus.hist_next = 1;
    tick(1);
    check("rst_val_next_cycle", bus.val_out, 32'd0);
    check("rst_led_next_cycle", {16'd0, bus.led_out}, 32'd0);
    rst = 0;
    bus.eth_v = 0;
    bus.agg_v = 0;
    bus.hist_next = 0;
    tick(3);
    check("rst_frame_discarded", bus.val_out, 32'd0);
    bus.mode = MODE_LAST;
    tick(2);
    check("rst_last_empty", bus.val_out, 32'd0);

    // History browsing while empty, then a single entry
    bus.mode = MODE_HIST;
    hist_pulse();
    hist_pulse();
    tick(2);
    check("hist_empty", bus.val_out, 32'd0);
    agg_write(32'hDEAD_BEEF);
    tick(2);
    check("hist_single", bus.val_out, 32'hDEAD_BEEF);
    hist_pulse();
    tick(2);
    check("hist_single_wrap", bus.val_out, 32'hDEAD_BEEF);

    // Saturation on the narrow-counter instance
    for (int f = 0; f < 300; f++) begin
      bus8.eth_v = 1;
      tick(1);
      bus8.eth_v = 0;
      tick(1);
    end
    tick(2);
    check("sat8_val", bus8.val_out, 32'd255);
    check("sat8_led", {16'd0, bus8.led_out}, 32'h0000_00FF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_eth_frame_monitor
